// File: rtl/mult_div_unit.sv
// Multicycle integer multiply/divide unit: shift-add multiply, restoring divide,
// signed/unsigned modes, registered hi/lo results and a divide-by-zero flag.
module mult_div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_zero
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DZ} state_t;

  state_t               state;
  logic [CW-1:0]        cnt;
  logic                 is_div;
  logic                 neg_res;
  logic                 neg_rem;
  logic [2*WIDTH-1:0]   acc;
  logic [WIDTH-1:0]     dvs;

  logic [WIDTH-1:0]     a_mag;
  logic [WIDTH-1:0]     b_mag;
  logic [WIDTH:0]       mul_sum;
  logic [WIDTH:0]       rem_sh;
  logic                 div_ge;
  logic [WIDTH-1:0]     div_rem;
  logic [2*WIDTH-1:0]   prod_fix;
  logic [WIDTH-1:0]     quo_fix;
  logic [WIDTH-1:0]     rem_fix;

  // Operand magnitudes, one iteration step of each algorithm, and sign fix-up
  always_comb begin
    a_mag    = (!op[0] && a[WIDTH-1]) ? -a : a;
    b_mag    = (!op[0] && b[WIDTH-1]) ? -b : b;
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, dvs} : '0);
    rem_sh   = acc[2*WIDTH-1:WIDTH-1];
    div_ge   = (rem_sh >= {1'b0, dvs});
    div_rem  = WIDTH'(rem_sh - {1'b0, dvs});
    prod_fix = neg_res ? -acc : acc;
    quo_fix  = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem_fix  = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      is_div   <= 1'b0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      acc      <= '0;
      dvs      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      div_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            busy     <= 1'b1;
            div_zero <= 1'b0;
            is_div   <= op[1];
            neg_res  <= !op[0] && (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_rem  <= !op[0] && a[WIDTH-1];
            // Multiply shifts the multiplier out of acc; divide shifts the dividend
            acc      <= {{WIDTH{1'b0}}, (op[1] ? a_mag : b_mag)};
            dvs      <= op[1] ? b_mag : a_mag;
            if (op[1] && (b == '0)) begin
              state <= DZ;
            end else begin
              cnt   <= CW'(WIDTH);
              state <= CALC;
            end
          end
        end
        CALC: begin
          if (is_div) begin
            if (div_ge) acc <= {div_rem, acc[WIDTH-2:0], 1'b1};
            else        acc <= {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
          end else begin
            acc <= {mul_sum, acc[WIDTH-1:1]};
          end
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) state <= FIX;
        end
        FIX: begin
          if (is_div) begin
            hi <= rem_fix;
            lo <= quo_fix;
          end else begin
            {hi, lo} <= prod_fix;
          end
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        DZ: begin
          div_zero <= 1'b1;
          done     <= 1'b1;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: a 32-bit and an 8-bit instance checked
// against a longint reference model plus directed literal results.
module tb_mult_div_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        start32, busy32, done32, dz32;
  logic [1:0]  op32;
  logic [31:0] a32, b32, hi32, lo32;
  logic        start8, busy8, done8, dz8;
  logic [1:0]  op8;
  logic [7:0]  a8, b8, hi8, lo8;

  mult_div_unit #(.WIDTH(32)) dut32 (
    .clk(clk), .reset(reset), .start(start32), .op(op32), .a(a32), .b(b32),
    .busy(busy32), .done(done32), .hi(hi32), .lo(lo32), .div_zero(dz32)
  );

  mult_div_unit #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .op(op8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .hi(hi8), .lo(lo8), .div_zero(dz8)
  );

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          k;
    int          lat;
  } exp_t;

  exp_t        q32[$];
  exp_t        q8[$];
  exp_t        e32, e8;
  logic [31:0] sh_hi[2];
  logic [31:0] sh_lo[2];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: sign-extend per mode, use SV truncating division and wrap to w bits
  function automatic void model(input int w, input logic [1:0] op,
                                input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] phi, input logic [31:0] plo,
                                output logic [31:0] hi, output logic [31:0] lo,
                                output logic dz);
    longint      sa, sb, q, r;
    logic [63:0] m, p;
    m  = (64'd1 << w) - 64'd1;
    sa = longint'({32'd0, a} & m);
    sb = longint'({32'd0, b} & m);
    if (!op[0] && a[w-1]) sa = sa - longint'(64'd1 << w);
    if (!op[0] && b[w-1]) sb = sb - longint'(64'd1 << w);
    dz = 1'b0;
    if (!op[1]) begin
      p  = 64'(sa * sb);
      hi = 32'((p >> w) & m);
      lo = 32'(p & m);
    end else if (sb == 0) begin
      hi = phi;
      lo = plo;
      dz = 1'b1;
    end else begin
      q  = sa / sb;
      r  = sa % sb;
      lo = 32'(64'(q) & m);
      hi = 32'(64'(r) & m);
    end
  endfunction

  // Drive one request (unit must be idle); expectation queued if a completion is due
  task automatic issue(input int u, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input bit expect_done);
    exp_t e;
    int   w;
    w = (u == 0) ? 32 : 8;
    model(w, op, a, b, sh_hi[u], sh_lo[u], e.hi, e.lo, e.dz);
    if (u == 0) begin
      op32 = op; a32 = a; b32 = b; start32 = 1'b1;
    end else begin
      op8 = op; a8 = a[7:0]; b8 = b[7:0]; start8 = 1'b1;
    end
    @(posedge clk);
    #1;
    start32 = 1'b0;
    start8  = 1'b0;
    e.k   = cyc;
    e.lat = e.dz ? 1 : w + 1;
    if (expect_done) begin
      sh_hi[u] = e.hi;
      sh_lo[u] = e.lo;
      if (u == 0) q32.push_back(e);
      else        q8.push_back(e);
    end
  endtask

  task automatic wait_done(input int u);
    int n;
    n = 0;
    while (((u == 0) ? q32.size() : q8.size()) != 0 && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("wait_timeout", 64'(n >= 200), 64'd0);
  endtask

  always @(negedge clk) begin
    if (!reset && done32) begin
      if (q32.size() == 0) begin
        check("u32_spurious_done", 64'(done32), 64'd0);
      end else begin
        e32 = q32.pop_front();
        check("u32_hi", 64'(hi32), 64'(e32.hi));
        check("u32_lo", 64'(lo32), 64'(e32.lo));
        check("u32_div_zero", 64'(dz32), 64'(e32.dz));
        check("u32_latency", 64'(cyc - e32.k), 64'(e32.lat));
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && done8) begin
      if (q8.size() == 0) begin
        check("u8_spurious_done", 64'(done8), 64'd0);
      end else begin
        e8 = q8.pop_front();
        check("u8_hi", 64'(hi8), 64'(e8.hi));
        check("u8_lo", 64'(lo8), 64'(e8.lo));
        check("u8_div_zero", 64'(dz8), 64'(e8.dz));
        check("u8_latency", 64'(cyc - e8.k), 64'(e8.lat));
      end
    end
  end

  initial begin
    logic [1:0]  rop;
    logic [31:0] ra, rb;
    reset = 1'b1;
    start32 = 1'b0; op32 = '0; a32 = '0; b32 = '0;
    start8  = 1'b0; op8  = '0; a8  = '0; b8  = '0;
    for (int i = 0; i < 2; i++) begin
      sh_hi[i] = '0;
      sh_lo[i] = '0;
    end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_busy", 64'(busy32), 64'd0);
    check("rst_done", 64'(done32), 64'd0);
    check("rst_hi", 64'(hi32), 64'd0);
    check("rst_lo", 64'(lo32), 64'd0);
    check("rst_dz", 64'(dz32), 64'd0);
    check("rst_hi8", 64'(hi8), 64'd0);

    // Signed multiply with mixed signs
    issue(0, 2'b00, 32'hFFFFFFFD, 32'd7, 1'b1);
    check("t1_busy", 64'(busy32), 64'd1);
    wait_done(0);
    check("t1_busy_after", 64'(busy32), 64'd0);
    check("t1_hi", 64'(hi32), 64'hFFFFFFFF);
    check("t1_lo", 64'(lo32), 64'hFFFFFFEB);

    // Unsigned full-range multiply, started in the done cycle of the previous op
    issue(0, 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
    wait_done(0);
    check("t2_hi", 64'(hi32), 64'hFFFFFFFE);
    check("t2_lo", 64'(lo32), 64'h00000001);

    // Signed divide and the most-negative / -1 wrap
    issue(0, 2'b10, 32'hFFFFFFF9, 32'd2, 1'b1);
    wait_done(0);
    check("t3_lo", 64'(lo32), 64'hFFFFFFFD);
    check("t3_hi", 64'(hi32), 64'hFFFFFFFF);
    issue(0, 2'b10, 32'h80000000, 32'hFFFFFFFF, 1'b1);
    wait_done(0);
    check("t3w_lo", 64'(lo32), 64'h80000000);
    check("t3w_hi", 64'(hi32), 64'h00000000);
    check("t3w_dz", 64'(dz32), 64'd0);

    // Divide by zero keeps hi/lo; back-to-back zero divides; flag clears on next op
    issue(0, 2'b01, 32'd3, 32'd5, 1'b1);
    wait_done(0);
    issue(0, 2'b11, 32'd100, 32'd0, 1'b1);
    wait_done(0);
    check("t4_dz", 64'(dz32), 64'd1);
    check("t4_hi", 64'(hi32), 64'd0);
    check("t4_lo", 64'(lo32), 64'd15);
    issue(0, 2'b10, 32'd9, 32'd0, 1'b1);
    wait_done(0);
    issue(0, 2'b11, 32'd100, 32'd7, 1'b1);
    wait_done(0);
    check("t4b_dz", 64'(dz32), 64'd0);
    check("t4b_lo", 64'(lo32), 64'd14);
    check("t4b_hi", 64'(hi32), 64'd2);

    // start while busy is ignored
    issue(0, 2'b00, 32'h00001234, 32'hFFFFFF00, 1'b1);
    repeat (4) @(negedge clk);
    op32 = 2'b11; a32 = 32'd99; b32 = 32'd77; start32 = 1'b1;
    @(posedge clk);
    #1;
    start32 = 1'b0;
    wait_done(0);
    check("t5_hi", 64'(hi32), 64'hFFFFFFFF);
    check("t5_lo", 64'(lo32), 64'hFFEDCC00);

    // Reset mid-operation aborts without a done pulse
    issue(0, 2'b01, 32'd5, 32'd6, 1'b0);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("t5r_busy", 64'(busy32), 64'd0);
    check("t5r_hi", 64'(hi32), 64'd0);
    check("t5r_lo", 64'(lo32), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      sh_hi[i] = '0;
      sh_lo[i] = '0;
    end
    repeat (40) @(negedge clk);
    #1;
    issue(0, 2'b01, 32'd6, 32'd7, 1'b1);
    wait_done(0);
    check("t5f_lo", 64'(lo32), 64'd42);

    // 8-bit instance
    issue(1, 2'b10, 32'h81, 32'h0A, 1'b1);
    wait_done(1);
    check("t6_lo", 64'(lo8), 64'hF4);
    check("t6_hi", 64'(hi8), 64'hF9);
    issue(1, 2'b01, 32'hFF, 32'hFF, 1'b1);
    wait_done(1);
    check("t6m_hi", 64'(hi8), 64'hFE);
    check("t6m_lo", 64'(lo8), 64'h01);
    issue(1, 2'b10, 32'h80, 32'hFF, 1'b1);
    wait_done(1);

    // Randomised mix against the reference model on both widths
    for (int u = 0; u < 2; u++) begin
      for (int i = 0; i < 24; i++) begin
        rop = 2'($urandom_range(0, 3));
        ra  = $urandom;
        case ($urandom_range(0, 4))
          0:       rb = 32'd0;
          1:       rb = 32'($urandom_range(1, 15));
          2:       rb = {{28{1'b1}}, 4'($urandom)};
          default: rb = $urandom;
        endcase
        if (u == 1 && rb[7:0] == 8'd0 && $urandom_range(0, 1) == 1) rb = rb | 32'd3;
        issue(u, rop, ra, rb, 1'b1);
        wait_done(u);
      end
    end

    repeat (5) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
